// File: rtl/pcileech_ft601_emu.sv
// Chip-side model of the FT601 245-sync FIFO bus. Host valid/ready streams feed and drain
// two first-word-fall-through FIFOs that the FPGA-side controller reads and writes over the pads.
module pcileech_ft601_emu #(
  parameter int PARAM_FIFO_DEPTH_LOG2 = 6,
  parameter int PARAM_TX_ROOM_MIN     = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ft601_dout,
  output logic        ft601_dout_oe,
  input  logic [31:0] ft601_din,
  input  logic [3:0]  ft601_be_in,
  output logic        ft601_rxf_n,
  output logic        ft601_txe_n,
  input  logic        ft601_rd_n,
  input  logic        ft601_oe_n,
  input  logic        ft601_wr_n,
  input  logic [31:0] h_tx_data,
  input  logic        h_tx_valid,
  output logic        h_tx_ready,
  output logic [35:0] h_rx_data,
  output logic        h_rx_valid,
  input  logic        h_rx_ready,
  output logic [31:0] cnt_rd_words,
  output logic [31:0] cnt_wr_words,
  output logic        err_underrun,
  output logic        err_overrun,
  output logic        err_protocol
);
  localparam int AW = PARAM_FIFO_DEPTH_LOG2;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ROOM_C  = (AW+1)'(PARAM_TX_ROOM_MIN);

  typedef enum logic [1:0] {S_IDLE, S_TA, S_DRIVE} state_t;
  state_t state, state_nxt;

  logic [31:0] rmem [2**AW];
  logic [35:0] wmem [2**AW];
  logic [AW:0] r_wptr, r_rptr, w_wptr, w_rptr;
  logic [AW:0] r_count, r_count_nxt, w_count, w_count_nxt, w_free_nxt;
  logic        drive, r_push, r_pop, w_push, w_pop;
  logic        underrun_ev, overrun_ev, protocol_ev;

  assign r_count    = r_wptr - r_rptr;
  assign w_count    = w_wptr - w_rptr;
  assign h_tx_ready = !rst && (r_count != DEPTH_C);
  assign h_rx_valid = (w_count != '0);
  assign h_rx_data  = wmem[w_rptr[AW-1:0]];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!ft601_oe_n) state_nxt = S_TA;
      S_TA:    state_nxt = ft601_oe_n ? S_IDLE : S_DRIVE;
      S_DRIVE: if (ft601_oe_n) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    drive         = (state == S_DRIVE);
    ft601_dout_oe = drive;
    ft601_dout    = (drive && r_count != '0) ? rmem[r_rptr[AW-1:0]] : 32'h0;
    r_push        = h_tx_valid && h_tx_ready;
    // A simultaneous write strobe takes priority; the read half of that cycle is ignored.
    r_pop         = drive && !ft601_rd_n && ft601_wr_n && !ft601_rxf_n && (r_count != '0);
    underrun_ev   = drive && !ft601_rd_n && ft601_wr_n && (ft601_rxf_n || r_count == '0);
    w_push        = !ft601_wr_n && !ft601_txe_n;
    overrun_ev    = !ft601_wr_n && ft601_txe_n;
    w_pop         = h_rx_valid && h_rx_ready;
    protocol_ev   = (!ft601_rd_n && !drive) || (!ft601_rd_n && !ft601_wr_n) ||
                    (!ft601_wr_n && ft601_dout_oe);
    r_count_nxt   = r_count + (AW+1)'(r_push) - (AW+1)'(r_pop);
    w_count_nxt   = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_free_nxt    = DEPTH_C - w_count_nxt;
  end

  always_ff @(posedge clk) begin
    if (r_push) rmem[r_wptr[AW-1:0]] <= h_tx_data;
    if (w_push) wmem[w_wptr[AW-1:0]] <= {ft601_be_in, ft601_din};
  end

  // Flags come from next-state counts so they line up with the registered pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      w_wptr       <= '0;
      w_rptr       <= '0;
      ft601_rxf_n  <= 1'b1;
      ft601_txe_n  <= 1'b1;
      cnt_rd_words <= '0;
      cnt_wr_words <= '0;
      err_underrun <= 1'b0;
      err_overrun  <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      state       <= state_nxt;
      ft601_rxf_n <= (r_count_nxt == '0);
      ft601_txe_n <= (w_free_nxt < ROOM_C);
      if (r_push) r_wptr <= r_wptr + 1'b1;
      if (r_pop) begin
        r_rptr       <= r_rptr + 1'b1;
        cnt_rd_words <= cnt_rd_words + 32'd1;
      end
      if (w_push) begin
        w_wptr       <= w_wptr + 1'b1;
        cnt_wr_words <= cnt_wr_words + 32'd1;
      end
      if (w_pop) w_rptr <= w_rptr + 1'b1;
      if (underrun_ev) err_underrun <= 1'b1;
      if (overrun_ev)  err_overrun  <= 1'b1;
      if (protocol_ev) err_protocol <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pcileech_ft601_emu.sv
// Bench for pcileech_ft601_emu: host-side pushes and controller writes queue expected words,
// which are popped and compared when the emulator presents them.
module tb_pcileech_ft601_emu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ft601_dout;
  logic        ft601_dout_oe;
  logic [31:0] ft601_din;
  logic [3:0]  ft601_be_in;
  logic        ft601_rxf_n, ft601_txe_n;
  logic        ft601_rd_n, ft601_oe_n, ft601_wr_n;
  logic [31:0] h_tx_data;
  logic        h_tx_valid, h_tx_ready;
  logic [35:0] h_rx_data;
  logic        h_rx_valid, h_rx_ready;
  logic [31:0] cnt_rd_words, cnt_wr_words;
  logic        err_underrun, err_overrun, err_protocol;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rq[$];
  logic [35:0] wq[$];
  logic [31:0] exp_r;
  logic [35:0] exp_w;

  pcileech_ft601_emu dut (
    .clk(clk), .rst(rst),
    .ft601_dout(ft601_dout), .ft601_dout_oe(ft601_dout_oe),
    .ft601_din(ft601_din), .ft601_be_in(ft601_be_in),
    .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
    .ft601_rd_n(ft601_rd_n), .ft601_oe_n(ft601_oe_n), .ft601_wr_n(ft601_wr_n),
    .h_tx_data(h_tx_data), .h_tx_valid(h_tx_valid), .h_tx_ready(h_tx_ready),
    .h_rx_data(h_rx_data), .h_rx_valid(h_rx_valid), .h_rx_ready(h_rx_ready),
    .cnt_rd_words(cnt_rd_words), .cnt_wr_words(cnt_wr_words),
    .err_underrun(err_underrun), .err_overrun(err_overrun), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ft601_din = '0; ft601_be_in = '0;
    ft601_rd_n = 1'b1; ft601_oe_n = 1'b1; ft601_wr_n = 1'b1;
    h_tx_data = '0; h_tx_valid = 1'b0; h_rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    rq.delete();
    wq.delete();
  endtask

  task automatic enter_drive();
    ft601_oe_n = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({ft601_rxf_n, ft601_txe_n, ft601_dout_oe, h_tx_ready, h_rx_valid} !== 5'b11000) begin
      $display("FAIL reset_flags got %b want 11000",
               {ft601_rxf_n, ft601_txe_n, ft601_dout_oe, h_tx_ready, h_rx_valid});
      miscompares++;
    end
    vectors++;
    if ({cnt_rd_words, cnt_wr_words, err_underrun, err_overrun, err_protocol, ft601_dout} !== '0) begin
      $display("FAIL reset_counters rd=%0d wr=%0d errs=%b%b%b dout=%h want all zero",
               cnt_rd_words, cnt_wr_words, err_underrun, err_overrun, err_protocol, ft601_dout);
      miscompares++;
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({ft601_rxf_n, ft601_txe_n, h_tx_ready} !== 3'b101) begin
      $display("FAIL post_reset_flags got %b want 101", {ft601_rxf_n, ft601_txe_n, h_tx_ready});
      miscompares++;
    end
  endtask

  task automatic test_read_burst();
    do_reset();
    h_tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      h_tx_data = 32'hA0 + i;
      rq.push_back(32'hA0 + i);
      tick();
    end
    h_tx_valid = 1'b0;
    vectors++;
    if (ft601_rxf_n !== 1'b0) begin
      $display("FAIL rxf_after_push got %b want 0", ft601_rxf_n); miscompares++;
    end
    enter_drive();
    vectors++;
    if (ft601_dout_oe !== 1'b1) begin
      $display("FAIL dout_oe_drive got %b want 1", ft601_dout_oe); miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      ft601_rd_n = 1'b0;
      exp_r = rq.pop_front();
      vectors++;
      if (ft601_dout !== exp_r) begin
        $display("FAIL read_word%0d got %h want %h", i, ft601_dout, exp_r); miscompares++;
      end
      tick();
    end
    ft601_rd_n = 1'b1;
    vectors++;
    if ({ft601_rxf_n, cnt_rd_words, err_underrun} !== {1'b1, 32'd3, 1'b0}) begin
      $display("FAIL read_burst_end rxf=%b cnt=%0d und=%b want 1 3 0",
               ft601_rxf_n, cnt_rd_words, err_underrun);
      miscompares++;
    end
    ft601_oe_n = 1'b1;
    tick();
    vectors++;
    if (ft601_dout_oe !== 1'b0) begin
      $display("FAIL dout_oe_release got %b want 0", ft601_dout_oe); miscompares++;
    end
  endtask

  task automatic test_underrun();
    do_reset();
    h_tx_valid = 1'b1; h_tx_data = 32'hB0; rq.push_back(32'hB0);
    tick();
    h_tx_valid = 1'b0;
    enter_drive();
    ft601_rd_n = 1'b0;
    exp_r = rq.pop_front();
    vectors++;
    if (ft601_dout !== exp_r) begin
      $display("FAIL underrun_word got %h want %h", ft601_dout, exp_r); miscompares++;
    end
    tick();
    tick();
    ft601_rd_n = 1'b1;
    vectors++;
    if ({err_underrun, cnt_rd_words} !== {1'b1, 32'd1}) begin
      $display("FAIL underrun_flag und=%b cnt=%0d want 1 1", err_underrun, cnt_rd_words);
      miscompares++;
    end
    h_tx_valid = 1'b1; h_tx_data = 32'hB1; rq.push_back(32'hB1);
    tick();
    h_tx_valid = 1'b0;
    ft601_rd_n = 1'b0;
    exp_r = rq.pop_front();
    vectors++;
    if (ft601_dout !== exp_r) begin
      $display("FAIL after_underrun_word got %h want %h", ft601_dout, exp_r); miscompares++;
    end
    tick();
    ft601_rd_n = 1'b1;
    vectors++;
    if ({cnt_rd_words, ft601_rxf_n} !== {32'd2, 1'b1}) begin
      $display("FAIL after_underrun_cnt cnt=%0d rxf=%b want 2 1", cnt_rd_words, ft601_rxf_n);
      miscompares++;
    end
  endtask

  task automatic test_write_fill();
    int bad_txe;
    int drained;
    do_reset();
    bad_txe = 0;
    ft601_be_in = 4'hF;
    for (int i = 0; i < 61; i++) begin
      if (ft601_txe_n !== 1'b0) bad_txe++;
      ft601_wr_n = 1'b0;
      ft601_din = 32'h1000 + i;
      wq.push_back({4'hF, 32'h1000 + i});
      tick();
    end
    vectors++;
    if (bad_txe != 0) begin
      $display("FAIL txe_during_fill got %0d cycles high want 0", bad_txe); miscompares++;
    end
    vectors++;
    if ({ft601_txe_n, cnt_wr_words, err_overrun} !== {1'b1, 32'd61, 1'b0}) begin
      $display("FAIL fill_end txe=%b cnt=%0d ovr=%b want 1 61 0",
               ft601_txe_n, cnt_wr_words, err_overrun);
      miscompares++;
    end
    ft601_din = 32'hDEAD;
    tick();
    ft601_wr_n = 1'b1;
    vectors++;
    if ({err_overrun, cnt_wr_words} !== {1'b1, 32'd61}) begin
      $display("FAIL overrun ovr=%b cnt=%0d want 1 61", err_overrun, cnt_wr_words);
      miscompares++;
    end
    h_rx_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 80 && h_rx_valid === 1'b1; c++) begin
      if (wq.size() == 0) begin
        vectors++;
        $display("FAIL drain_extra got %h want nothing", h_rx_data); miscompares++;
        break;
      end
      exp_w = wq.pop_front();
      vectors++;
      if (h_rx_data !== exp_w) begin
        $display("FAIL drain_word%0d got %h want %h", drained, h_rx_data, exp_w); miscompares++;
      end
      drained++;
      tick();
    end
    h_rx_ready = 1'b0;
    tick();
    vectors++;
    if ({drained, ft601_txe_n} !== {32'd61, 1'b0}) begin
      $display("FAIL drain_count got %0d txe=%b want 61 0", drained, ft601_txe_n);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset();
    h_tx_valid = 1'b1; h_tx_data = 32'h0; rq.push_back(32'h0);
    tick();
    h_tx_valid = 1'b0;
    enter_drive();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      h_tx_valid = 1'b1;
      h_tx_data = 32'h5000_0000 + i + 1;
      ft601_rd_n = 1'b0;
      exp_r = rq.pop_front();
      if (ft601_dout !== exp_r || h_tx_ready !== 1'b1) begin
        if (bad < 4) $display("FAIL stream_word%0d got %h want %h", i, ft601_dout, exp_r);
        bad++;
      end
      rq.push_back(h_tx_data);
      tick();
    end
    h_tx_valid = 1'b0;
    ft601_rd_n = 1'b1;
    vectors++;
    if (bad != 0) miscompares++;
    vectors++;
    if ({cnt_rd_words, err_underrun, err_protocol, ft601_rxf_n} !== {32'd200, 3'b000}) begin
      $display("FAIL stream_end cnt=%0d und=%b prot=%b rxf=%b want 200 0 0 0",
               cnt_rd_words, err_underrun, err_protocol, ft601_rxf_n);
      miscompares++;
    end
  endtask

  task automatic test_protocol();
    do_reset();
    h_tx_valid = 1'b1; h_tx_data = 32'hC0; rq.push_back(32'hC0);
    tick();
    h_tx_valid = 1'b0;
    ft601_oe_n = 1'b0;
    tick();
    ft601_rd_n = 1'b0;
    tick();
    ft601_rd_n = 1'b1;
    vectors++;
    if ({err_protocol, cnt_rd_words, ft601_dout} !== {1'b1, 32'd0, rq[0]}) begin
      $display("FAIL rd_in_ta prot=%b cnt=%0d dout=%h want 1 0 %h",
               err_protocol, cnt_rd_words, ft601_dout, rq[0]);
      miscompares++;
    end
    rst = 1'b1; tick(); rst = 1'b0;
    ft601_oe_n = 1'b1;
    tick();
    h_tx_valid = 1'b1; h_tx_data = 32'hC1;
    tick();
    h_tx_valid = 1'b0;
    enter_drive();
    ft601_rd_n = 1'b0; ft601_wr_n = 1'b0;
    ft601_din = 32'h1234_5678; ft601_be_in = 4'h3;
    wq.push_back({4'h3, 32'h1234_5678});
    tick();
    ft601_rd_n = 1'b1; ft601_wr_n = 1'b1;
    exp_w = wq.pop_front();
    vectors++;
    if ({err_protocol, cnt_wr_words, cnt_rd_words, h_rx_valid} !== {1'b1, 32'd1, 32'd0, 1'b1}) begin
      $display("FAIL rd_wr_both prot=%b wr=%0d rd=%0d vld=%b want 1 1 0 1",
               err_protocol, cnt_wr_words, cnt_rd_words, h_rx_valid);
      miscompares++;
    end
    vectors++;
    if ({h_rx_data, ft601_dout} !== {exp_w, 32'hC1}) begin
      $display("FAIL rd_wr_data got %h/%h want %h/%h", h_rx_data, ft601_dout, exp_w, 32'hC1);
      miscompares++;
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    h_tx_valid = 1'b1; ft601_wr_n = 1'b0; ft601_be_in = 4'hF;
    for (int i = 0; i < 10; i++) begin
      h_tx_data = 32'h7000 + i;
      ft601_din = 32'h8000 + i;
      tick();
    end
    h_tx_valid = 1'b0; ft601_wr_n = 1'b1;
    enter_drive();
    vectors++;
    if ({cnt_wr_words, ft601_dout_oe, ft601_dout} !== {32'd10, 1'b1, 32'h7000}) begin
      $display("FAIL midburst_setup wr=%0d oe=%b dout=%h want 10 1 7000",
               cnt_wr_words, ft601_dout_oe, ft601_dout);
      miscompares++;
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({ft601_rxf_n, ft601_txe_n, ft601_dout_oe, h_rx_valid, cnt_rd_words, cnt_wr_words} !==
        {4'b1100, 64'd0}) begin
      $display("FAIL midburst_reset rxf=%b txe=%b oe=%b vld=%b rd=%0d wr=%0d want 1 1 0 0 0 0",
               ft601_rxf_n, ft601_txe_n, ft601_dout_oe, h_rx_valid, cnt_rd_words, cnt_wr_words);
      miscompares++;
    end
    rst = 1'b0;
    ft601_oe_n = 1'b1;
    tick();
    vectors++;
    if ({ft601_rxf_n, h_rx_valid, ft601_txe_n} !== 3'b100) begin
      $display("FAIL midburst_flushed rxf=%b vld=%b txe=%b want 1 0 0",
               ft601_rxf_n, h_rx_valid, ft601_txe_n);
      miscompares++;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_read_burst();
    test_underrun();
    test_write_fill();
    test_back_to_back();
    test_protocol();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
